mixer_coeff_bank: RTL
=====================

Name: mixer_coeff_bank

Overview:
Parametrised, double-buffered coefficient store for the audio mixer matrix. Host writes go to a shadow bank. A commit request is applied atomically on the next sample boundary. Active coefficients then ramp linearly toward the committed targets, one step per sample, which removes zipper noise. The block sits between the host register interface and the mixer datapath and presents one output channel's full gain vector per cycle.

Parameters:
NUM_INPUTS, 6, number of mixer input channels; entry 0 is the output gain, entries 1..NUM_INPUTS are input gains
NUM_OUTPUTS, 4, number of mixer output channels
COEFF_W, 16, coefficient width, signed two's complement
ADDR_W, 4, width of address and config_id fields
RAMP_STEP, 256, maximum magnitude change per sample_tick; 0 = jump directly to target

Ports:
CLK  in  1  system clock, all logic on rising edge
nRST  in  1  asynchronous, active-low reset
wr_en  in  1  write shadow[wr_out_addr][wr_in_addr] <= wr_data
wr_data  in  COEFF_W  coefficient to write
wr_in_addr  in  ADDR_W  entry index, 0..NUM_INPUTS
wr_out_addr  in  ADDR_W  output channel, 0..NUM_OUTPUTS-1
wr_err  out  1  one-cycle pulse, address out of range, write dropped
rd_en  in  1  readback request, uses wr_in_addr/wr_out_addr
rd_active  in  1  readback source: 0 = shadow, 1 = active
rd_data  out  COEFF_W  readback value
rd_valid  out  1  one-cycle pulse qualifying rd_data
commit_req  in  1  single-cycle request to commit shadow to target
sample_tick  in  1  single-cycle sample-rate strobe from the audio clock domain logic
commit_busy  out  1  high while state != IDLE
ramping  out  1  high in RAMP state
config_id  in  ADDR_W  output channel whose active vector is presented
coeff_bus  out  (NUM_INPUTS+1)*COEFF_W  active[config_id]; slice k = bits [k*COEFF_W +: COEFF_W]

Behaviour:
- Storage: shadow, target and active arrays, each NUM_OUTPUTS x (NUM_INPUTS+1) x COEFF_W.
- Reset, asynchronous on nRST low:
  - All three arrays = 0 and state = IDLE.
  - wr_err, rd_valid, rd_data = 0.
  - coeff_bus, commit_busy and ramping = 0.
- Writes:
  - Applied one cycle after wr_en, in any state.
  - Out-of-range address (wr_in_addr > NUM_INPUTS or wr_out_addr >= NUM_OUTPUTS): write dropped, wr_err = 1 on the next cycle.
- Readback:
  - rd_data and rd_valid are registered, with 1-cycle latency.
  - Out-of-range address returns 0 with rd_valid = 1.
  - rd_en and wr_en to the same address in the same cycle returns the old value.
- coeff_bus is combinational from active and config_id. An out-of-range config_id drives all zeros.
- State machine:
  - IDLE: commit_req -> ARMED. A sample_tick in the same cycle as commit_req is not consumed.
  - ARMED:
    - On sample_tick: target <= shadow, a snapshot of the pre-write value if wr_en is in the same cycle.
    - If RAMP_STEP == 0: active <= shadow also, next state IDLE.
    - Otherwise next state RAMP.
    - commit_req while in ARMED is ignored.
  - RAMP:
    - On each sample_tick, every entry steps toward its target.
    - Difference d = target - active, computed in COEFF_W+1 bits (no overflow).
    - If |d| <= RAMP_STEP: active <= target. Otherwise active <= active +/- RAMP_STEP.
    - The ramp never overshoots and never wraps.
    - When active == target for all entries, go to IDLE on the next clock.
    - commit_req in RAMP -> ARMED; active holds its current values and the ramp restarts from them after the next commit tick.
- Ramp length: a full-scale move from -32768 to +32767 with step 256 completes in 256 ticks.
- Entries with d = 0 stay constant throughout.
- Reset mid-ramp or in ARMED: all arrays clear immediately and the pending commit is lost.

Test Plan:
1. Reset, write shadow[1][3] = 0x1000, read back with rd_active = 0 -> rd_data = 0x1000 after 1 cycle. coeff_bus slice 3 with config_id = 1 stays 0 (no commit yet).
2. Commit, then 17 sample_ticks with RAMP_STEP = 256 -> slice 3 reads 0x0100, 0x0200, ... 0x1000 at tick 16. ramping drops 1 cycle after tick 16.
3. Write 0x0080 to shadow[0][0] with active 0 and commit -> 0x0080 after one ramp tick (no overshoot). Write -512 (0xFE00) to shadow[0][0] with active 0 and commit -> 0xFF00 then 0xFE00.
4. wr_out_addr = 4 or wr_in_addr = 7 -> wr_err pulses, all arrays unchanged. config_id = 5 -> coeff_bus = 0.
5. commit_req mid-ramp after shadow changes to 0x0000 -> active freezes, and after the next tick ramps back down to 0.
6. Assert nRST during RAMP -> coeff_bus = 0, commit_busy = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/mixer_coeff_bank.sv
// mixer_coeff_bank
// Double-buffered coefficient store for the audio mixer matrix. The host
// writes a shadow bank. A commit copies shadow into target on the next sample
// boundary. The active coefficients then move linearly toward target by at
// most RAMP_STEP per sample_tick, which avoids zipper noise.
//
// Ports:
//   CLK, nRST         clock (rising edge) and asynchronous active-low reset
//   wr_en/wr_data     host write of shadow[wr_out_addr][wr_in_addr]
//   wr_in_addr        entry index 0..NUM_INPUTS (0 = output gain)
//   wr_out_addr       output channel 0..NUM_OUTPUTS-1
//   wr_err            one-cycle pulse when a write address is out of range
//   rd_en/rd_active   readback request and source (0 = shadow, 1 = active)
//   rd_data/rd_valid  registered readback result, 1-cycle latency
//   commit_req        request to commit shadow to target
//   sample_tick       sample-rate strobe
//   commit_busy       commit pending or ramp in progress
//   ramping           ramp in progress
//   config_id         output channel whose active vector drives coeff_bus
//   coeff_bus         active[config_id], entry k at bits [k*COEFF_W +: COEFF_W]
module mixer_coeff_bank #(
    parameter int NUM_INPUTS  = 6,
    parameter int NUM_OUTPUTS = 4,
    parameter int COEFF_W     = 16,
    parameter int ADDR_W      = 4,
    parameter int RAMP_STEP   = 256
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               wr_en,
    input  logic [COEFF_W-1:0]                 wr_data,
    input  logic [ADDR_W-1:0]                  wr_in_addr,
    input  logic [ADDR_W-1:0]                  wr_out_addr,
    output logic                               wr_err,
    input  logic                               rd_en,
    input  logic                               rd_active,
    output logic [COEFF_W-1:0]                 rd_data,
    output logic                               rd_valid,
    input  logic                               commit_req,
    input  logic                               sample_tick,
    output logic                               commit_busy,
    output logic                               ramping,
    input  logic [ADDR_W-1:0]                  config_id,
    output logic [(NUM_INPUTS+1)*COEFF_W-1:0]  coeff_bus
);

    localparam int NUM_ENTRIES = NUM_INPUTS + 1;
    localparam int IN_IDX_W    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int OUT_IDX_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam logic signed [COEFF_W:0] STEP_X = (COEFF_W+1)'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;

    state_t             state;
    logic [COEFF_W-1:0] shadow [NUM_OUTPUTS][NUM_ENTRIES];
    logic [COEFF_W-1:0] target [NUM_OUTPUTS][NUM_ENTRIES];
    logic [COEFF_W-1:0] active [NUM_OUTPUTS][NUM_ENTRIES];

    logic                 addr_ok;
    logic                 cfg_ok;
    logic [IN_IDX_W-1:0]  in_idx;
    logic [OUT_IDX_W-1:0] out_idx;
    logic [OUT_IDX_W-1:0] cfg_idx;
    logic                 all_settled;

    assign addr_ok = (int'(wr_in_addr) <= NUM_INPUTS) && (int'(wr_out_addr) < NUM_OUTPUTS);
    assign cfg_ok  = int'(config_id) < NUM_OUTPUTS;
    assign in_idx  = wr_in_addr[IN_IDX_W-1:0];
    assign out_idx = wr_out_addr[OUT_IDX_W-1:0];
    assign cfg_idx = config_id[OUT_IDX_W-1:0];

    assign commit_busy = (state != IDLE);
    assign ramping     = (state == RAMP);

    // One ramp step. The difference is taken one bit wider than the
    // coefficient so full-scale moves cannot overflow; when the remaining
    // distance is within one step we land exactly on the target, so the
    // result can neither overshoot nor wrap.
    function automatic logic [COEFF_W-1:0] step_toward(input logic [COEFF_W-1:0] cur,
                                                       input logic [COEFF_W-1:0] tgt);
        logic signed [COEFF_W:0] cur_x;
        logic signed [COEFF_W:0] tgt_x;
        logic signed [COEFF_W:0] diff;
        logic        [COEFF_W:0] mag;
        cur_x = {cur[COEFF_W-1], cur};
        tgt_x = {tgt[COEFF_W-1], tgt};
        diff  = tgt_x - cur_x;
        mag   = diff[COEFF_W] ? $unsigned(-diff) : $unsigned(diff);
        if (mag <= $unsigned(STEP_X))
            return tgt;
        else if (diff[COEFF_W])
            return cur - STEP_X[COEFF_W-1:0];
        else
            return cur + STEP_X[COEFF_W-1:0];
    endfunction

    always_comb begin
        all_settled = 1'b1;
        for (int o = 0; o < NUM_OUTPUTS; o++)
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (active[o][i] != target[o][i])
                    all_settled = 1'b0;
    end

    always_comb begin
        coeff_bus = '0;
        if (cfg_ok)
            for (int k = 0; k < NUM_ENTRIES; k++)
                coeff_bus[k*COEFF_W +: COEFF_W] = active[cfg_idx][k];
    end

    // Host writes land in the shadow bank regardless of commit state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int o = 0; o < NUM_OUTPUTS; o++)
                for (int i = 0; i < NUM_ENTRIES; i++)
                    shadow[o][i] <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !addr_ok;
            if (wr_en && addr_ok)
                shadow[out_idx][in_idx] <= wr_data;
        end
    end

    // Readback samples the arrays before any same-cycle write takes effect.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!addr_ok)
                    rd_data <= '0;
                else if (rd_active)
                    rd_data <= active[out_idx][in_idx];
                else
                    rd_data <= shadow[out_idx][in_idx];
            end
        end
    end

    // Commit sequencing. A new commit during a ramp freezes active where it
    // is; the next commit tick reloads target and the ramp resumes from there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            for (int o = 0; o < NUM_OUTPUTS; o++)
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    target[o][i] <= '0;
                    active[o][i] <= '0;
                end
        end else begin
            case (state)
                IDLE: begin
                    if (commit_req)
                        state <= ARMED;
                end
                ARMED: begin
                    if (sample_tick) begin
                        for (int o = 0; o < NUM_OUTPUTS; o++)
                            for (int i = 0; i < NUM_ENTRIES; i++)
                                target[o][i] <= shadow[o][i];
                        if (RAMP_STEP == 0) begin
                            for (int o = 0; o < NUM_OUTPUTS; o++)
                                for (int i = 0; i < NUM_ENTRIES; i++)
                                    active[o][i] <= shadow[o][i];
                            state <= IDLE;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (commit_req)
                        state <= ARMED;
                    else if (all_settled)
                        state <= IDLE;
                    else if (sample_tick)
                        for (int o = 0; o < NUM_OUTPUTS; o++)
                            for (int i = 0; i < NUM_ENTRIES; i++)
                                active[o][i] <= step_toward(active[o][i], target[o][i]);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
